// File: rtl/gpr_xfer_ctrl.sv
// Micro-sequencer for the GPR bank on the shared W bus: runs MOV/ADD/LDI/SWAP
// as a fixed sequence of registered (Moore) bus enables, at most one W-bus driver per cycle.
module gpr_xfer_ctrl #(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned SEL_WIDTH        = 3,
    parameter bit          R0_WRITE_PROTECT = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [SEL_WIDTH-1:0]  req_rd,
    input  logic [SEL_WIDTH-1:0]  req_rs,
    input  logic [DATA_WIDTH-1:0] req_imm,
    output logic                  GPR_in,
    output logic                  GPR_out,
    output logic [SEL_WIDTH-1:0]  GPR_select,
    output logic                  T1_in,
    output logic                  T2_in,
    output logic                  T1_out,
    output logic                  T2_out,
    output logic                  ALU_out,
    output logic                  imm_out,
    output logic [DATA_WIDTH-1:0] imm_bus,
    output logic                  done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_RS  = 3'd1;
    localparam logic [2:0] RD_RD  = 3'd2;
    localparam logic [2:0] WR_T1  = 3'd3;
    localparam logic [2:0] WR_ALU = 3'd4;
    localparam logic [2:0] WR_IMM = 3'd5;
    localparam logic [2:0] WR_T2  = 3'd6;

    localparam logic [1:0] OP_MOV  = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_LDI  = 2'd2;
    localparam logic [1:0] OP_SWAP = 2'd3;

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [SEL_WIDTH-1:0]  rd_q, rd_d, rs_q, rs_d;
    logic [DATA_WIDTH-1:0] imm_d;
    logic                  accept;
    logic                  prot_rd, prot_rs;

    logic                  gpr_in_d, gpr_out_d, t1_in_d, t2_in_d;
    logic                  t1_out_d, t2_out_d, alu_out_d, imm_out_d, done_d;
    logic [SEL_WIDTH-1:0]  sel_d;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        op_d  = op_q;
        rd_d  = rd_q;
        rs_d  = rs_q;
        imm_d = imm_bus;
        if (accept) begin
            op_d  = req_op;
            rd_d  = req_rd;
            rs_d  = req_rs;
            imm_d = req_imm;
        end

        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = (req_op == OP_LDI) ? WR_IMM : RD_RS;
            RD_RS:  state_d = (op_q == OP_MOV) ? WR_T1 : RD_RD;
            RD_RD:  state_d = (op_q == OP_ADD) ? WR_ALU : WR_T1;
            WR_T1:  state_d = (op_q == OP_SWAP) ? WR_T2 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the state's own cycle.
    assign prot_rd = R0_WRITE_PROTECT && (rd_d == '0);
    assign prot_rs = R0_WRITE_PROTECT && (rs_d == '0);

    always_comb begin
        gpr_in_d  = 1'b0;
        gpr_out_d = 1'b0;
        t1_in_d   = 1'b0;
        t2_in_d   = 1'b0;
        t1_out_d  = 1'b0;
        t2_out_d  = 1'b0;
        alu_out_d = 1'b0;
        imm_out_d = 1'b0;
        sel_d     = '0;
        case (state_d)
            RD_RS: begin
                gpr_out_d = 1'b1;
                sel_d     = rs_d;
                t1_in_d   = 1'b1;
            end
            RD_RD: begin
                gpr_out_d = 1'b1;
                sel_d     = rd_d;
                t2_in_d   = 1'b1;
            end
            WR_T1: begin
                sel_d    = rd_d;
                t1_out_d = !prot_rd;
                gpr_in_d = !prot_rd;
            end
            WR_ALU: begin
                sel_d     = rd_d;
                alu_out_d = !prot_rd;
                gpr_in_d  = !prot_rd;
            end
            WR_IMM: begin
                sel_d     = rd_d;
                imm_out_d = !prot_rd;
                gpr_in_d  = !prot_rd;
            end
            WR_T2: begin
                sel_d    = rs_d;
                t2_out_d = !prot_rs;
                gpr_in_d = !prot_rs;
            end
            default: ;
        endcase
        done_d = (state_d == IDLE) && (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            imm_bus    <= '0;
            GPR_in     <= 1'b0;
            GPR_out    <= 1'b0;
            GPR_select <= '0;
            T1_in      <= 1'b0;
            T2_in      <= 1'b0;
            T1_out     <= 1'b0;
            T2_out     <= 1'b0;
            ALU_out    <= 1'b0;
            imm_out    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            imm_bus    <= imm_d;
            GPR_in     <= gpr_in_d;
            GPR_out    <= gpr_out_d;
            GPR_select <= sel_d;
            T1_in      <= t1_in_d;
            T2_in      <= t2_in_d;
            T1_out     <= t1_out_d;
            T2_out     <= t2_out_d;
            ALU_out    <= alu_out_d;
            imm_out    <= imm_out_d;
            done       <= done_d;
        end
    end

endmodule
